// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: DMA has priority, with a CPU anti-starvation override.
// One transfer at a time goes to a registered memory port, and a WAIT-state timeout aborts stalled transfers.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_we,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_width,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_width,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ok,
  output logic        owner,
  output logic        busy
);

  // state | meaning
  // IDLE  | sample requests, latch winner onto the mem_* port
  // ISSUE | strobe asserted, mem_ok ignored
  // WAIT  | strobe held until mem_ok or timeout
  // DONE  | owner ack (and err) pulse, strobes low
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] tmo_cnt;
  logic       cpu_wins;

  assign cpu_wins = cpu_req && (!dma_req || starve_cnt == STARVE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      tmo_cnt    <= 8'd0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      dma_err    <= 1'b0;
      cpu_rdata  <= 32'd0;
      dma_rdata  <= 32'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_width  <= 2'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_err <= 1'b0;
      dma_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!cpu_req)
            starve_cnt <= 4'd0;
          if (cpu_req || dma_req) begin
            if (cpu_wins) begin
              mem_addr   <= cpu_addr;
              mem_wdata  <= cpu_wdata;
              mem_width  <= cpu_width;
              mem_read   <= ~cpu_we;
              mem_write  <= cpu_we;
              owner      <= 1'b0;
              starve_cnt <= 4'd0;
            end else begin
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
              mem_width <= dma_width;
              mem_read  <= ~dma_we;
              mem_write <= dma_we;
              owner     <= 1'b1;
              // CPU lost while waiting: count toward its forced grant
              if (cpu_req && starve_cnt < STARVE_MAX)
                starve_cnt <= starve_cnt + 4'd1;
            end
            tmo_cnt <= TMO_LOAD;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mem_ok) begin
            if (mem_read) begin
              if (owner) dma_rdata <= mem_rdata;
              else       cpu_rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_ack   <= ~owner;
            dma_ack   <= owner;
            state     <= DONE;
          end else if (tmo_cnt == 8'd1) begin
            if (owner) dma_rdata <= 32'd0;
            else       cpu_rdata <= 32'd0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_ack   <= ~owner;
            dma_ack   <= owner;
            cpu_err   <= ~owner;
            dma_err   <= owner;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        DONE: begin
          tmo_cnt <= 8'd0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts each ack
// (side, cycle, err, rdata, strobe length), and a negedge monitor pops and compares.
module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 64;

  logic clk = 1'b0, rst_n = 1'b1;
  logic cpu_req = 1'b0, dma_req = 1'b0, cpu_we = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = '0, dma_addr = '0, cpu_wdata = '0, dma_wdata = '0;
  logic [1:0]  cpu_width = '0, dma_width = '0;
  logic        cpu_ack, dma_ack, cpu_err, dma_err, mem_read, mem_write, owner, busy;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_width;
  logic        mem_ok;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_width(cpu_width),
    .cpu_we(cpu_we), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_width(dma_width),
    .dma_we(dma_we), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ok(mem_ok),
    .owner(owner), .busy(busy)
  );

  // memory contents and per-address wait-state count
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0300_0010) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic int ok_delay(input logic [31:0] a);
    if (a[31:28] == 4'hF) return 200;
    return int'(a[9:8]);
  endfunction

  // memory responder: ok random in ISSUE (must be ignored), then after ok_delay WAIT cycles
  int   scnt;
  logic ok_rand = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) scnt <= 0;
    else if (mem_read || mem_write) scnt <= scnt + 1;
    else scnt <= 0;
  always @(negedge clk) ok_rand <= 1'($urandom_range(0, 1));
  assign mem_rdata = mem_model(mem_addr);
  assign mem_ok = (mem_read || mem_write) &&
                  ((scnt == 0) ? ok_rand : (scnt >= 1 + ok_delay(mem_addr)));

  typedef struct {
    bit          who;
    int          ack_cyc;
    bit          err;
    logic [31:0] rd_cpu, rd_dma, addr, wdata;
    logic [1:0]  width;
    bit          we;
    int          slen;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          free_at = 0;
  int          starve_m = 0;
  int          grant_cnt[2] = '{0, 0};
  logic [31:0] rd_m[2] = '{32'd0, 32'd0};
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // reference model: one transfer at a time, arbiter free again the cycle after the ack
  always @(posedge clk) begin : model
    exp_t e;
    int   d;
    bit   w;
    if (!rst_n) begin
      exp_q.delete();
      free_at  = 0;
      starve_m = 0;
      rd_m[0]  = 32'd0;
      rd_m[1]  = 32'd0;
    end else if (cyc >= free_at) begin
      if (!cpu_req) starve_m = 0;
      if (cpu_req || dma_req) begin
        w = dma_req && !(cpu_req && starve_m >= STARVE_LIMIT);
        if (w && cpu_req) starve_m = (starve_m >= STARVE_LIMIT) ? STARVE_LIMIT : starve_m + 1;
        if (!w) starve_m = 0;
        e.who   = w;
        e.addr  = w ? dma_addr : cpu_addr;
        e.wdata = w ? dma_wdata : cpu_wdata;
        e.width = w ? dma_width : cpu_width;
        e.we    = w ? dma_we : cpu_we;
        d = ok_delay(e.addr);
        if (d >= TIMEOUT) begin
          e.err     = 1'b1;
          e.ack_cyc = cyc + 2 + TIMEOUT;
          e.slen    = 1 + TIMEOUT;
          rd_m[w]   = 32'd0;
        end else begin
          e.err     = 1'b0;
          e.ack_cyc = cyc + 3 + d;
          e.slen    = 2 + d;
          if (!e.we) rd_m[w] = mem_model(e.addr);
        end
        e.rd_cpu = rd_m[0];
        e.rd_dma = rd_m[1];
        free_at  = e.ack_cyc + 1;
        grant_cnt[w] = grant_cnt[w] + 1;
        exp_q.push_back(e);
      end
    end
  end

  int   scnt_mon = 0, excl_bad = 0, stray_bad = 0;
  bit   last_read = 1'b0;
  bit   log_order = 1'b0;
  bit   order_q[$];
  exp_t em;

  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      scnt_mon = 0;
    end else begin
      if (mem_read && mem_write) excl_bad++;
      if ((cpu_err && !cpu_ack) || (dma_err && !dma_ack) || (cpu_ack && dma_ack)) stray_bad++;
      if (mem_read || mem_write) begin
        scnt_mon++;
        last_read = mem_read;
      end
      if (cpu_ack || dma_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'({dma_ack, cpu_ack}), 32'd0);
        end else begin
          em = exp_q.pop_front();
          chk("ack_side", 32'({dma_ack, cpu_ack}), em.who ? 32'd2 : 32'd1);
          chk("ack_cycle", 32'(cyc), 32'(em.ack_cyc));
          chk("err", 32'(em.who ? dma_err : cpu_err), 32'(em.err));
          chk("cpu_rdata", cpu_rdata, em.rd_cpu);
          chk("dma_rdata", dma_rdata, em.rd_dma);
          chk("mem_addr", mem_addr, em.addr);
          chk("mem_width", 32'(mem_width), 32'(em.width));
          if (em.we) chk("mem_wdata", mem_wdata, em.wdata);
          chk("strobe_len", 32'(scnt_mon), 32'(em.slen));
          chk("strobe_kind", 32'(last_read), 32'(!em.we));
          chk("busy_owner", 32'({busy, owner}), 32'({1'b1, em.who}));
          if (log_order) order_q.push_back(dma_ack);
        end
        scnt_mon = 0;
      end else if (exp_q.size() > 0 && cyc > exp_q[0].ack_cyc) begin
        chk("missing_ack", 32'(cyc), 32'(exp_q[0].ack_cyc));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_req(input bit who, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] w, input logic we, input bit drop, input int gap);
    int g0, n;
    bit got;
    g0 = grant_cnt[who];
    if (!who) begin
      cpu_addr = a; cpu_wdata = wd; cpu_width = w; cpu_we = we; cpu_req = 1'b1;
    end else begin
      dma_addr = a; dma_wdata = wd; dma_width = w; dma_we = we; dma_req = 1'b1;
    end
    if (drop) begin
      n = 0;
      while (grant_cnt[who] == g0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!who) cpu_req = 1'b0; else dma_req = 1'b0;
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      got = who ? dma_ack : cpu_ack;
    end
    chk(who ? "dma_ack_wait" : "cpu_ack_wait", 32'(got), 32'd1);
    if (!who) cpu_req = 1'b0; else dma_req = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic rand_stream(input bit who, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = $urandom;
      if (a[31:28] == 4'hF) a[31:28] = 4'h1;
      if ($urandom_range(0, 24) == 0) a[31:28] = 4'hF;
      do_req(who, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0, $urandom_range(0, 4));
    end
  endtask

  bit exp_order[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, dma_seen;
    bit got;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ctrl", 32'({cpu_ack, dma_ack, cpu_err, dma_err, mem_read, mem_write, busy, owner}), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_mem_width", 32'(mem_width), 32'd0);
    chk("reset_cpu_rdata", cpu_rdata, 32'd0);
    chk("reset_dma_rdata", dma_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b0, 32'h0300_0010, 32'd0, 2'd2, 1'b0, 1'b0, 2);
    do_req(1'b1, 32'h0000_0104, 32'h1234_5678, 2'd1, 1'b1, 1'b0, 2);
    do_req(1'b0, 32'hF000_0000, 32'd0, 2'd2, 1'b0, 1'b0, 1);
    do_req(1'b0, 32'h0000_0020, 32'd0, 2'd2, 1'b0, 1'b0, 1);

    fork
      rand_stream(1'b0, 40);
      rand_stream(1'b1, 40);
    join
    repeat (5) @(negedge clk);

    // both requesting back-to-back from an idle arbiter with the starve count cleared
    log_order = 1'b1;
    fork
      for (int i = 0; i < 2; i++) do_req(1'b0, 32'h2000_0000 + 32'(i * 4), 32'd0, 2'd2, 1'b0, 1'b0, 0);
      for (int i = 0; i < 8; i++) do_req(1'b1, 32'h2100_0000 + 32'(i * 4), 32'd0, 2'd2, 1'b0, 1'b0, 0);
    join
    @(negedge clk);
    log_order = 1'b0;
    chk("order_len", 32'(order_q.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < order_q.size()) chk("grant_order", 32'(order_q[i]), 32'(exp_order[i]));
    repeat (3) @(negedge clk);

    // reset during the WAIT of a DMA write with a CPU read pending
    cpu_addr = 32'h0400_0040; cpu_wdata = 32'd0; cpu_width = 2'd2; cpu_we = 1'b0; cpu_req = 1'b1;
    dma_addr = 32'h0000_0300; dma_wdata = 32'hCAFE_F00D; dma_width = 2'd1; dma_we = 1'b1; dma_req = 1'b1;
    n = 0;
    while (!mem_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 32'({mem_write, mem_read, busy, owner, dma_ack, cpu_ack}), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    dma_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    dma_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        got = 1'b1;
        cpu_req = 1'b0;
      end
      if (dma_ack) dma_seen++;
    end
    chk("post_rst_cpu_ack", 32'(got), 32'd1);
    chk("post_rst_dma_ack", 32'(dma_seen), 32'd0);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("strobe_exclusive", 32'(excl_bad), 32'd0);
    chk("stray_ack_err", 32'(stray_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
